// File: rtl/dmem_arbiter_if.sv
// Bundle of requester-side handshake and memory-side bus signals for dmem_arbiter.
// slave is the arbiter's view; master is the requesters'/memory's view.
interface dmem_arbiter_if;
  logic       req0;
  logic       req1;
  logic       we0;
  logic       we1;
  logic [7:0] addr0;
  logic [7:0] addr1;
  logic [7:0] wdata0;
  logic [7:0] wdata1;
  logic       ack0;
  logic       ack1;
  logic [7:0] rdata0;
  logic [7:0] rdata1;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       owner;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata0, rdata1, mem_read, mem_write, mem_addr, mem_wdata,
           busy, owner
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata0, rdata1, mem_read, mem_write, mem_addr, mem_wdata,
           busy, owner
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the 256x8 data memory: one transaction at a time.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; default is fixed priority to port 0.
module dmem_arbiter #(
  parameter int unsigned READ_WAIT = 1
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(READ_WAIT);

  state_t     state;
  logic [3:0] cnt;
  logic       any_req;
  logic       win;
  logic       win_we;
  logic [7:0] win_addr;
  logic [7:0] win_wdata;

`ifdef DMEM_ARB_RR_EN
  logic       rr_last;
`endif

  always_comb begin
    any_req = bus.req0 | bus.req1;
`ifdef DMEM_ARB_RR_EN
    // On a tie the port not served last wins; otherwise whoever is asking.
    if (bus.req0 && bus.req1) win = ~rr_last;
    else                      win = ~bus.req0;
`else
    win = ~bus.req0;
`endif
    win_we    = win ? bus.we1    : bus.we0;
    win_addr  = win ? bus.addr1  : bus.addr0;
    win_wdata = win ? bus.wdata1 : bus.wdata0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.ack0      <= 1'b0;
      bus.ack1      <= 1'b0;
      bus.busy      <= 1'b0;
      bus.owner     <= 1'b0;
      bus.mem_addr  <= 8'h00;
      bus.mem_wdata <= 8'h00;
      bus.rdata0    <= 8'h00;
      bus.rdata1    <= 8'h00;
`ifdef DMEM_ARB_RR_EN
      rr_last       <= 1'b1;
`endif
    end else begin
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            bus.owner     <= win;
            bus.mem_addr  <= win_addr;
            bus.mem_wdata <= win_wdata;
            bus.busy      <= 1'b1;
            cnt           <= WAIT_LOAD;
`ifdef DMEM_ARB_RR_EN
            rr_last       <= win;
`endif
            if (win_we) begin
              bus.mem_write <= 1'b1;
              state         <= WR;
            end else begin
              bus.mem_read  <= 1'b1;
              state         <= RD;
            end
          end
        end
        WR: begin
          bus.mem_write <= 1'b0;
          bus.ack0      <= ~bus.owner;
          bus.ack1      <= bus.owner;
          state         <= DONE;
        end
        RD: begin
          // mem_rdata has settled by the last read cycle; capture on that edge.
          if (cnt == 4'd1) begin
            if (bus.owner) bus.rdata1 <= bus.mem_rdata;
            else           bus.rdata0 <= bus.mem_rdata;
            bus.mem_read <= 1'b0;
            bus.ack0     <= ~bus.owner;
            bus.ack1     <= bus.owner;
            state        <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 256x8 memory model (async read, sync write).
module tb_dmem_arbiter;

  localparam int RW = 3;
`ifdef DMEM_ARB_RR_EN
  localparam logic [3:0] TIE_EXP = 4'b0101;
`else
  localparam logic [3:0] TIE_EXP = 4'b0000;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.READ_WAIT(RW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [0:255];
  logic       pre_en;
  logic [7:0] pre_addr;
  logic [7:0] pre_data;

  always @(posedge clk) begin
    if (pre_en)             mem[pre_addr]     <= pre_data;
    else if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = mem[bus.mem_addr];

  int ack0_cnt = 0;
  int ack1_cnt = 0;
  always @(posedge clk) begin
    if (bus.ack0) ack0_cnt <= ack0_cnt + 1;
    if (bus.ack1) ack1_cnt <= ack1_cnt + 1;
  end

  int   checks = 0;
  int   errors = 0;
  int   rd_cyc;
  int   wr_cyc;
  logic addr_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic r, input logic w,
                       input logic [7:0] a, input logic [7:0] d);
    if (!p) begin
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    tick();
    pre_en   = 1'b0;
  endtask

  // Issues one transaction from an idle arbiter; lat = cycles from sample edge to ack.
  task automatic txn(input logic p, input logic w, input logic [7:0] a,
                     input logic [7:0] d, output int lat);
    logic got;
    drive(p, 1'b1, w, a, d);
    lat = 0; rd_cyc = 0; wr_cyc = 0; addr_bad = 1'b0; got = 1'b0;
    while (!got && lat < 40) begin
      tick();
      lat++;
      if (bus.mem_read)  rd_cyc++;
      if (bus.mem_write) wr_cyc++;
      if ((bus.mem_read || bus.mem_write) && bus.mem_addr != a) addr_bad = 1'b1;
      got = p ? bus.ack1 : bus.ack0;
    end
    drive(p, 1'b0, w, a, d);
    tick();
  endtask

  initial begin
    int lat, t, n, gap, idle_cyc, t0, t1, acks;
    logic [3:0] seq;

    rst = 1'b1;
    pre_en = 1'b0; pre_addr = 8'h00; pre_data = 8'h00;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) tick();

    chk("rst_ctl", 32'({bus.busy, bus.owner, bus.ack0, bus.ack1, bus.mem_read, bus.mem_write}), 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_wdata", 32'(bus.mem_wdata), 0);
    chk("rst_rdata", 32'({bus.rdata1, bus.rdata0}), 0);
    rst = 1'b0;
    tick();

    // Port 0 write then read back
    txn(1'b0, 1'b1, 8'h10, 8'hA5, lat);
    chk("wr_lat", lat, 2);
    chk("wr_pulse", wr_cyc, 1);
    chk("wr_mem", 32'(mem[8'h10]), 'hA5);
    txn(1'b0, 1'b0, 8'h10, 8'h00, lat);
    chk("rd_lat", lat, RW + 1);
    chk("rd_data0", 32'(bus.rdata0), 'hA5);
    chk("rd_no_ack1", ack1_cnt, 0);

    // Port 1 read with long settle time
    preload(8'hFF, 8'h3C);
    txn(1'b1, 1'b0, 8'hFF, 8'h00, lat);
    chk("p1_lat", lat, RW + 1);
    chk("p1_rd_cycles", rd_cyc, RW);
    chk("p1_addr_stable", 32'(addr_bad), 0);
    chk("p1_rdata1", 32'(bus.rdata1), 'h3C);
    chk("p1_rdata0_held", 32'(bus.rdata0), 'hA5);
    chk("p1_owner", 32'(bus.owner), 1);

    // Reset during a port 1 read
    acks = ack0_cnt + ack1_cnt;
    drive(1'b1, 1'b1, 1'b0, 8'h10, 8'h00);
    tick(); tick();
    chk("rstrd_pre", 32'({bus.busy, bus.mem_read, bus.owner}), 'b111);
    rst = 1'b1;
    #1;
    chk("rstrd_out", 32'({bus.busy, bus.mem_read, bus.owner, bus.ack1}), 0);
    chk("rstrd_addr", 32'(bus.mem_addr), 0);
    drive(1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rstrd_noack", ack0_cnt + ack1_cnt, acks);
    chk("rstrd_rdata1", 32'(bus.rdata1), 0);

    // Reset during a write, before the write edge
    preload(8'h05, 8'h11);
    acks = ack0_cnt + ack1_cnt;
    drive(1'b0, 1'b1, 1'b1, 8'h05, 8'h77);
    tick();
    chk("rstwr_pre", 32'(bus.mem_write), 1);
    rst = 1'b1;
    #1;
    chk("rstwr_out", 32'({bus.mem_write, bus.busy, bus.ack0}), 0);
    drive(1'b0, 1'b0, 1'b1, 8'h05, 8'h77);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rstwr_mem", 32'(mem[8'h05]), 'h11);
    chk("rstwr_noack", ack0_cnt + ack1_cnt, acks);

    // Tie: both ports hold write requests across four decisions
    drive(1'b0, 1'b1, 1'b1, 8'h20, 8'h01);
    drive(1'b1, 1'b1, 1'b1, 8'h21, 8'h02);
    seq = 4'b0000; n = 0; t = 0;
    while (n < 4 && t < 60) begin
      tick();
      t++;
      if (bus.ack0) begin seq = {seq[2:0], 1'b0}; n++; end
      else if (bus.ack1) begin seq = {seq[2:0], 1'b1}; n++; end
    end
    drive(1'b0, 1'b0, 1'b1, 8'h20, 8'h01);
    drive(1'b1, 1'b0, 1'b1, 8'h21, 8'h02);
    tick();
    chk("tie_count", n, 4);
    chk("tie_order", 32'(seq), 32'(TIE_EXP));
    txn(1'b1, 1'b1, 8'h21, 8'h02, lat);
    chk("tie_mem20", 32'(mem[8'h20]), 'h01);
    chk("tie_mem21", 32'(mem[8'h21]), 'h02);

    // Port 0 keeps req high across ack
    drive(1'b0, 1'b1, 1'b1, 8'h30, 8'h5A);
    n = 0; t = 0; gap = 0; idle_cyc = 0;
    while (n < 2 && t < 40) begin
      tick();
      t++;
      if (n == 1) begin
        gap++;
        if (!bus.busy) idle_cyc++;
      end
      if (bus.ack0) n++;
    end
    drive(1'b0, 1'b0, 1'b1, 8'h30, 8'h5A);
    tick();
    chk("cont_acks", n, 2);
    chk("cont_spacing", gap, 3);
    chk("cont_idle", idle_cyc, 1);
    chk("cont_mem", 32'(mem[8'h30]), 'h5A);

    // Port 1 read arrives while port 0 is mid-write
    txn(1'b0, 1'b0, 8'h10, 8'h00, lat);
    preload(8'h00, 8'hC3);
    drive(1'b0, 1'b1, 1'b1, 8'h40, 8'h66);
    tick();
    drive(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    t = 0; t0 = -1; t1 = -1;
    while ((t0 < 0 || t1 < 0) && t < 40) begin
      tick();
      t++;
      if (bus.ack0) begin t0 = t; drive(1'b0, 1'b0, 1'b1, 8'h40, 8'h66); end
      if (bus.ack1) begin t1 = t; drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00); end
    end
    drive(1'b0, 1'b0, 1'b1, 8'h40, 8'h66);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk("mid_ack0_first", t0, 1);
    chk("mid_gap", t1 - t0, RW + 2);
    chk("mid_rdata1", 32'(bus.rdata1), 'hC3);
    chk("mid_rdata0_held", 32'(bus.rdata0), 'hA5);
    chk("mid_mem40", 32'(mem[8'h40]), 'h66);
    chk("mid_idle", 32'({bus.busy, bus.mem_read, bus.mem_write}), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the 256x8 data memory. Two requesters share the memory's single read/write port: port 0 is the processor datapath and port 1 is the loader/debug port. The block latches one transaction at a time, drives the memory's `mem_read`/`mem_write`/address/data inputs, waits out the read settle time, and returns data with a one-cycle acknowledge.

## Interface
- `READ_WAIT`, default 1: number of cycles `mem_read` is held before `mem_rdata` is sampled. Legal range 1..15.
- `clk`  in  1  rising-edge system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req0`/`req1`  in  1  transaction request, per port.
- `we0`/`we1`  in  1  per port: 1 = write, 0 = read.
- `addr0`/`addr1`  in  8  memory address, per port.
- `wdata0`/`wdata1`  in  8  write data, per port.
- `ack0`/`ack1`  out  1  one-cycle transaction-complete pulse, per port.
- `rdata0`/`rdata1`  out  8  last read result for that port.
- `mem_read`  out  1  to the memory's read enable.
- `mem_write`  out  1  to the memory's write enable.
- `mem_addr`  out  8  to the memory's address input.
- `mem_wdata`  out  8  to the memory's ALU-data input.
- `mem_rdata`  in  8  from the memory's data output.
- `busy`  out  1  high in any state other than IDLE.
- `owner`  out  1  index of the port owning the current or most recent transaction.

## Operation
- FSM states: IDLE, WR, RD, DONE.
- **IDLE**
  - If any `req` is high, pick a winner (see Configuration).
  - Latch the winner's `we`, `addr` and `wdata` into internal registers and set `owner`.
  - Go to WR if `we`=1, else to RD. Load the wait counter with `READ_WAIT`.
  - If no `req` is high, stay in IDLE.
- **WR**
  - `mem_write`=1 for exactly one cycle; the memory captures data on the edge that ends this cycle.
  - Go to DONE.
- **RD**
  - `mem_read`=1 for every RD cycle; the counter decrements each cycle.
  - On the edge where the counter equals 1, capture `mem_rdata` into `rdata[owner]` and go to DONE.
- **DONE**
  - `ack[owner]`=1 for this cycle only, then go to IDLE.
- `mem_addr` and `mem_wdata` are driven from the latched registers in every state, so they stay stable for the whole transaction. They hold their last value in IDLE.
- Requester rules:
  - Hold `req`, `we`, `addr` and `wdata` stable until `ack` is seen.
  - Drop `req` on the same edge at which `ack`=1 is sampled.
  - A `req` still high in IDLE is treated as a new transaction.
- `rdata0`/`rdata1` change only on a read capture for that port; they hold otherwise.
- The non-owning port's request is ignored until the FSM returns to IDLE. It is never dropped, only delayed.
- Reset (asynchronous, any state):
  - FSM goes to IDLE.
  - `mem_read`, `mem_write`, `ack0`, `ack1`, `busy`, `owner` are 0.
  - `mem_addr`, `mem_wdata`, `rdata0`, `rdata1` are 8'h00.
  - Round-robin pointer is set to 1.
  - An in-flight transaction is aborted with no `ack`; any write not yet clocked is not performed. The requester must reissue.

## Timing
- Request sampled at edge E0 means the FSM enters WR/RD after E0.
- Write: `mem_write` high in cycle E0–E1; memory is updated at E1; `ack` is high in cycle E1–E2.
- Read: `mem_read` high from E0 to E(READ_WAIT); data is captured at E(READ_WAIT); `ack` is high in the following cycle, with `rdata` already valid.
- Transaction latency from sample to ack:
  - Write: 2 cycles.
  - Read: READ_WAIT+1 cycles.
  - Minimum spacing between back-to-back transactions is 3 cycles (write) or READ_WAIT+2 cycles (read), because IDLE is always visited.
- The memory's output settle delay (2 ns) must be less than one clock period. The clock period is ≥10 ns.
- `ack`, `busy`, `owner`, `mem_read` and `mem_write` are registered or decoded from state only. There are no combinational paths from `req`.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin arbitration.
  - When both `req` lines are high in IDLE, the port not served last wins.
  - The pointer updates when a winner is latched.
  - After reset, port 0 wins the first tie.
- `DMEM_ARB_RR_EN` undefined: fixed priority.
  - Port 0 always wins a tie.
  - Port 1 is served only when `req0`=0 in IDLE.
- A single request with no contention behaves identically in both builds.

## Test plan
- Reset, then port 0 writes 8'hA5 to 8'h10 and then reads 8'h10 → `ack0` comes 2 cycles after the write sample; after the read, `rdata0`=8'hA5 with `ack0` READ_WAIT+1 cycles after the read sample; `ack1` stays 0.
- `req0` and `req1` both issue writes in the same cycle (8'h01→8'h20, 8'h02→8'h21) → fixed build serves port 0 first; RR build alternates 0,1,0,1 over four repeated tie rounds. Memory contents are correct in both builds.
- READ_WAIT=3, port 1 reads 8'hFF after memory preload 8'h3C → `mem_read` high for 3 cycles, `mem_addr`=8'hFF stable throughout, `rdata1`=8'h3C at `ack1`.
- Assert `rst` during RD (read) and again during WR (write of 8'h77 to 8'h05) → outputs go to 0 immediately and no `ack` is issued; location 8'h05 is unchanged if `rst` was raised before the WR edge.
- Port 0 keeps `req0` high across `ack0` → a second transaction starts; `busy` remains 1 except for one IDLE cycle.
- Port 1 read of 8'h00 while port 0 is mid-write → port 1 is served immediately after port 0's DONE; `rdata0` is unchanged.
